// File: rtl/parity_frame_tx_if.sv
// ---------------------------------------------------------------------------
// parity_frame_tx_if
// Purpose : valid/ready word interface between the odd parity generator and
//           the parity_frame_tx serializer.
// Signals :
//   in_data   - word to transmit (DATA_W bits)
//   in_parity - odd parity bit belonging to in_data
//   in_valid  - in_data/in_parity are valid (held until accepted)
//   in_ready  - serializer can accept a word this cycle
// Modports: master (upstream source), slave (serializer)
// ---------------------------------------------------------------------------
interface parity_frame_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_parity,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_parity,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/parity_frame_tx.sv
// ---------------------------------------------------------------------------
// parity_frame_tx
// Purpose : UART-style serializer for the parity-protected link. Accepts a
//           data word plus its odd parity bit and sends
//           start(0), data LSB first, parity, stop(1); each bit is held for
//           CLKS_PER_BIT clocks. Transmit only.
// Parameters:
//   DATA_W       - data word width in bits (default 8)
//   CLKS_PER_BIT - clocks per serial bit, 1..65535 (default 4)
// Ports   :
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   inBus   - parity_frame_tx_if.slave (in_data, in_parity, in_valid, in_ready)
//   tx      - registered serial line, idles high
//   busy    - frame in progress (START..STOP)
//   tx_done - one-cycle pulse on the last stop-bit cycle
//   par_err - one-cycle pulse when the incoming parity bit is wrong
// Build option:
//   PARITY_CHECK_EN - when defined, parity is recomputed on accept, a
//                     mismatch raises par_err and the corrected parity is
//                     sent. When undefined, in_parity is sent verbatim and
//                     par_err is tied low.
// ---------------------------------------------------------------------------
module parity_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  parity_frame_tx_if.slave    inBus,
  output logic                tx,
  output logic                busy,
  output logic                tx_done,
  output logic                par_err
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [BAUD_W-1:0] r_baudCnt;
  logic [BAUD_W-1:0] w_baudCntNext;
  logic [BIT_W-1:0]  r_bitCnt;
  logic [BIT_W-1:0]  w_bitCntNext;
  logic [DATA_W-1:0] r_shiftReg;
  logic [DATA_W-1:0] w_shiftNext;
  logic              r_parity;
  logic              w_parityNext;
  logic              r_tx;
  logic              w_txNext;
  logic              w_accept;
  logic              w_bitEnd;
  logic              w_parityIn;

  assign w_accept = inBus.in_valid && (r_state == IDLE);
  assign w_bitEnd = (r_baudCnt == BAUD_LAST);

`ifdef PARITY_CHECK_EN
  logic r_parErr;

  // The recomputed parity is what goes on the line, so a corrupted
  // upstream parity bit is reported but never propagated.
  assign w_parityIn = ~^inBus.in_data;

  // Registered so the pulse lines up with the first start-bit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parErr <= 1'b0;
    end else begin
      r_parErr <= w_accept && (w_parityIn != inBus.in_parity);
    end
  end

  assign par_err = r_parErr;
`else
  assign w_parityIn = inBus.in_parity;
  assign par_err    = 1'b0;
`endif

  // Next-state logic. The baud counter runs in every non-idle state and
  // wraps on each bit boundary; the shift register moves only at the end
  // of a data bit. tx is computed from the *next* state so the registered
  // line changes on the same edge as the state, giving one clock latency.
  always_comb begin
    w_nextState   = r_state;
    w_baudCntNext = r_baudCnt;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shiftReg;
    w_parityNext  = r_parity;
    w_txNext      = 1'b1;

    if (r_state != IDLE) begin
      w_baudCntNext = w_bitEnd ? '0 : r_baudCnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState   = START;
          w_shiftNext   = inBus.in_data;
          w_parityNext  = w_parityIn;
          w_baudCntNext = '0;
          w_bitCntNext  = '0;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_shiftNext = r_shiftReg >> 1;
          if (r_bitCnt == BIT_LAST) begin
            w_bitCntNext = '0;
            w_nextState  = PARITY;
          end else begin
            w_bitCntNext = r_bitCnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bitEnd) begin
          w_nextState = STOP;
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    case (w_nextState)
      IDLE:    w_txNext = 1'b1;
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      PARITY:  w_txNext = w_parityNext;
      STOP:    w_txNext = 1'b1;
      default: w_txNext = 1'b1;
    endcase
  end

  // Reset drops the line straight back to idle-high so an abandoned frame
  // never leaves a stale data bit on tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baudCnt  <= '0;
      r_bitCnt   <= '0;
      r_shiftReg <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_nextState;
      r_baudCnt  <= w_baudCntNext;
      r_bitCnt   <= w_bitCntNext;
      r_shiftReg <= w_shiftNext;
      r_parity   <= w_parityNext;
      r_tx       <= w_txNext;
    end
  end

  assign inBus.in_ready = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign tx_done        = (r_state == STOP) && w_bitEnd;
  assign tx             = r_tx;

endmodule

// File: tb/tb_parity_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_tx
// Purpose : self-checking bench for parity_frame_tx (DATA_W=8,
//           CLKS_PER_BIT=4). Stimulus pushes the expected frame into a
//           queue on each accepted word; a monitor detects start bits on tx,
//           records one full frame of tx/tx_done/busy/par_err and compares
//           it against the queue head.
// ---------------------------------------------------------------------------
module tb_parity_frame_tx;

  localparam int DATA_W    = 8;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = (DATA_W + 3) * CPB;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  logic tx;
  logic busy;
  logic tx_done;
  logic par_err;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycleCount  = 0;
  int   readyHigh   = 0;
  logic countReady  = 1'b0;
  logic monBusy     = 1'b0;

  exp_t expQ[$];
  int   startCycles[$];

  parity_frame_tx_if #(.DATA_W(DATA_W)) bus ();

  parity_frame_tx #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inBus   (bus),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done),
    .par_err (par_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount++;

  always @(negedge clk) begin
    if (countReady && bus.in_ready === 1'b1) readyHigh++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] txPattern(input logic [7:0] d, input logic p);
    logic [10:0] bits;
    logic [63:0] v;
    v    = '0;
    bits = {1'b1, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < CPB; c++) begin
        v[k*CPB + c] = bits[k];
      end
    end
    return v;
  endfunction

  // Presents a word, waits (bounded) for in_ready, and records the expected
  // frame once the accepting edge has passed. in_valid is left high.
  task automatic applyStimulus(input logic [7:0] d, input logic p,
                               input logic expPar, input logic expErr);
    int waitCycles;
    exp_t e;
    waitCycles = 0;
    @(negedge clk);
    bus.in_data   = d;
    bus.in_parity = p;
    bus.in_valid  = 1'b1;
    while (bus.in_ready !== 1'b1 && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 200) begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
      return;
    end
    @(posedge clk);
    e.data = d;
    e.par  = expPar;
    e.err  = expErr;
    expQ.push_back(e);
  endtask

  task automatic releaseValid();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || monBusy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) checkOutput("drainTimeout", 64'd1, 64'd0);
  endtask

  // Monitor: a low tx outside reset marks the first start-bit cycle; the
  // next FRAME_CYC samples form one frame. A reset seen mid-frame discards
  // both the capture and the queued expectation.
  initial begin
    logic [63:0] obsTx;
    logic [63:0] obsDone;
    logic [63:0] obsBusy;
    logic [63:0] obsErr;
    logic        aborted;
    logic        hasExp;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        monBusy = 1'b1;
        startCycles.push_back(cycleCount);
        hasExp  = (expQ.size() != 0);
        if (!hasExp) checkOutput("unexpectedFrame", 64'd1, 64'd0);
        obsTx   = '0;
        obsDone = '0;
        obsBusy = '0;
        obsErr  = '0;
        aborted = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          obsTx[i]   = tx;
          obsDone[i] = tx_done;
          obsBusy[i] = busy;
          obsErr[i]  = par_err;
        end
        if (hasExp) begin
          e = expQ.pop_front();
          if (!aborted) begin
            checkOutput($sformatf("frameTx[%h]", e.data), obsTx, txPattern(e.data, e.par));
            checkOutput($sformatf("txDone[%h]", e.data), obsDone, 64'd1 << (FRAME_CYC - 1));
            checkOutput($sformatf("busy[%h]", e.data), obsBusy, (64'd1 << FRAME_CYC) - 64'd1);
            checkOutput($sformatf("parErr[%h]", e.data), obsErr, {63'd0, e.err});
          end
        end
        monBusy = 1'b0;
      end
    end
  end

  initial begin
    int idleBad;
    int base;
    logic parExp;
    logic errExp;
    logic toggle;
    int n;
    exp_t e;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_parity = 1'b0;

    // Reset state while rst_n is held low.
    repeat (3) @(negedge clk);
    checkOutput("resetState", {59'd0, tx, bus.in_ready, busy, tx_done, par_err}, 64'b11000);
    rst_n = 1'b1;

    // Idle hold: 20 cycles with no valid word.
    idleBad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({tx, bus.in_ready, busy, tx_done, par_err} !== 5'b11000) idleBad++;
    end
    checkOutput("idleHold", 64'(idleBad), 64'd0);

    // Single frame from the reference example.
    applyStimulus(8'b11101010, 1'b0, 1'b0, 1'b0);
    releaseValid();
    waitDrain();

    // Back-to-back frames with in_valid held high throughout.
    base = startCycles.size();
    applyStimulus(8'b10101011, 1'b0, 1'b0, 1'b0);
    countReady = 1'b1;
    applyStimulus(8'b11111110, 1'b0, 1'b0, 1'b0);
    countReady = 1'b0;
    releaseValid();
    waitDrain();
    checkOutput("readyGap", 64'(readyHigh), 64'd1);
    if (startCycles.size() >= base + 2)
      checkOutput("b2bSpacing", 64'(startCycles[base+1] - startCycles[base]), 64'(FRAME_CYC + 1));
    else
      checkOutput("b2bFrames", 64'(startCycles.size() - base), 64'd2);

    // Inputs toggling while busy; only the word present when in_ready is
    // high may be taken.
    applyStimulus(8'h0F, 1'b1, 1'b1, 1'b0);
    toggle = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      bus.in_data   = toggle ? 8'hFF : 8'h00;
      bus.in_parity = toggle;
      toggle        = ~toggle;
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checkOutput("toggleTimeout", 64'd0, 64'd1);
    end else begin
      bus.in_data   = 8'h81;
      bus.in_parity = 1'b1;
      @(posedge clk);
      e.data = 8'h81;
      e.par  = 1'b1;
      e.err  = 1'b0;
      expQ.push_back(e);
    end
    releaseValid();
    waitDrain();

    // Reset during data bit 3 (clocks 17..20 after the accepting edge).
    applyStimulus(8'hC3, 1'b1, 1'b1, 1'b0);
    releaseValid();
    repeat (17) @(negedge clk);
    checkOutput("preResetTx", {63'd0, tx}, 64'd0);
    #2 rst_n = 1'b0;
    #1 checkOutput("resetMidFrame", {60'd0, tx, bus.in_ready, busy, tx_done}, 64'b1100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitDrain();
    applyStimulus(8'b00101010, 1'b0, 1'b0, 1'b0);
    releaseValid();
    waitDrain();

    // Wrong incoming parity bit.
`ifdef PARITY_CHECK_EN
    parExp = 1'b0;
    errExp = 1'b1;
`else
    parExp = 1'b1;
    errExp = 1'b0;
`endif
    applyStimulus(8'b10001010, 1'b1, parExp, errExp);
    releaseValid();
    waitDrain();

    repeat (5) @(negedge clk);
    checkOutput("finalIdle", {60'd0, tx, bus.in_ready, busy, tx_done}, 64'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
